// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: op codes and
// return-address-stack sizing helper.
package pc_seq_pkg;

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_CALL = 3'b001;
  localparam logic [2:0] OP_RET  = 3'b010;
  localparam logic [2:0] OP_SEQ  = 3'b011;
  localparam logic [2:0] OP_JMP  = 3'b100;
  localparam logic [2:0] OP_JR   = 3'b101;
  localparam logic [2:0] OP_BT   = 3'b110;
  localparam logic [2:0] OP_BF   = 3'b111;

  // Pointer width for a stack of the given depth; never narrower than one bit.
  function automatic int ras_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; a pop from an empty stack leaves all state untouched.
module pc_ras
  import pc_seq_pkg::*;
#(
  parameter int RAS_DEPTH = 4,
  parameter int PC_W      = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [PC_W-1:0] push_data_i,
  output logic [PC_W-1:0] pop_data_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            ovf_o,
  output logic            unf_o
);

  localparam int PW = ras_ptr_w(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [PC_W-1:0] mem_q [RAS_DEPTH];
  logic [PW-1:0]   top_q, top_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  assign full_o     = (cnt_q == CW'(RAS_DEPTH));
  assign empty_o    = (cnt_q == '0);
  assign ovf_o      = push_i & full_o;
  assign unf_o      = pop_i & empty_o;
  assign pop_data_o = mem_q[top_q];

  // top_q indexes the newest entry; power-of-two depth lets the pointer wrap freely.
  always_comb begin
    top_d = top_q;
    cnt_d = cnt_q;
    if (push_i) begin
      top_d = top_q + PW'(1);
      cnt_d = full_o ? cnt_q : cnt_q + CW'(1);
    end else if (pop_i && !empty_o) begin
      top_d = top_q - PW'(1);
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      top_q <= '0;
      cnt_q <= '0;
    end else begin
      top_q <= top_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[top_d] <= push_data_i;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: next-PC selection, redirect priority, stall and
// a return-address stack for CALL/RET.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              PC_W      = 32,
  parameter int              IMM_W     = 16,
  parameter logic [PC_W-1:0] RESET_VEC = '0,
  parameter int              RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             op_valid,
  input  logic [2:0]       op,
  input  logic [IMM_W-1:0] imm,
  input  logic [PC_W-1:0]  jreg,
  input  logic             cond,
  input  logic             stall,
  input  logic             redirect,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  pc,
  output logic             taken,
  output logic             ras_ovf,
  output logic             ras_unf
);

  localparam logic [PC_W-1:0] FOUR     = PC_W'(4);
  localparam logic [PC_W-1:0] LOW_MASK = (PC_W'(1) << (IMM_W + 2)) - PC_W'(1);
  localparam logic [PC_W-1:0] WORD_MSK = ~PC_W'(3);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            taken_q, taken_d;
  logic            ovf_q, ovf_d;
  logic            unf_q, unf_d;

  logic            ras_push, ras_pop;
  logic [PC_W-1:0] ras_top;
  logic            ras_full, ras_empty, ras_ovf_w, ras_unf_w;

  logic [PC_W-1:0] seq_pc, region_pc, branch_pc, imm_sext;

  assign seq_pc    = pc_q + FOUR;
  assign region_pc = (pc_q & ~LOW_MASK) | (PC_W'(imm) << 2);
  assign imm_sext  = PC_W'($signed(imm));
  assign branch_pc = pc_q + (imm_sext << 2);

  // Inputs are qualified by op_valid and sampled on the rising edge; stall
  // overrides everything, and redirect outranks any op in the same cycle.
  always_comb begin
    pc_d     = pc_q;
    taken_d  = 1'b0;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (!stall) begin
      if (redirect) begin
        pc_d    = redirect_pc & WORD_MSK;
        taken_d = 1'b1;
      end else if (op_valid) begin
        case (op)
          OP_CALL: begin
            ras_push = 1'b1;
            pc_d     = region_pc;
            taken_d  = 1'b1;
          end
          OP_RET: begin
            ras_pop = 1'b1;
            pc_d    = ras_empty ? seq_pc : ras_top;
            taken_d = !ras_empty;
          end
          OP_SEQ: pc_d = seq_pc;
          OP_JMP: begin
            pc_d    = region_pc;
            taken_d = 1'b1;
          end
          OP_JR: begin
            pc_d    = jreg & WORD_MSK;
            taken_d = 1'b1;
          end
          OP_BT: begin
            pc_d    = cond ? branch_pc : seq_pc;
            taken_d = cond;
          end
          OP_BF: begin
            pc_d    = cond ? seq_pc : branch_pc;
            taken_d = !cond;
          end
          default: pc_d = pc_q;
        endcase
      end
    end
    ovf_d = ras_ovf_w;
    unf_d = ras_unf_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_VEC;
      taken_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      taken_q <= taken_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  pc_ras #(
    .RAS_DEPTH (RAS_DEPTH),
    .PC_W      (PC_W)
  ) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (ras_push),
    .pop_i       (ras_pop),
    .push_data_i (seq_pc),
    .pop_data_o  (ras_top),
    .full_o      (ras_full),
    .empty_o     (ras_empty),
    .ovf_o       (ras_ovf_w),
    .unf_o       (ras_unf_w)
  );

  assign pc      = pc_q;
  assign taken   = taken_q;
  assign ras_ovf = ovf_q;
  assign ras_unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random ops,
// scored against a queue-based reference model.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  localparam int PC_W      = 32;
  localparam int IMM_W     = 16;
  localparam int RAS_DEPTH = 4;
  localparam int EW        = PC_W + 3;

  logic             clk;
  logic             rst_n;
  logic             op_valid;
  logic [2:0]       op;
  logic [IMM_W-1:0] imm;
  logic [PC_W-1:0]  jreg;
  logic             cond;
  logic             stall;
  logic             redirect;
  logic [PC_W-1:0]  redirect_pc;
  logic [PC_W-1:0]  pc;
  logic             taken;
  logic             ras_ovf;
  logic             ras_unf;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0]   exp_q[$];
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_ras[$];

  pc_sequencer #(
    .PC_W      (PC_W),
    .IMM_W     (IMM_W),
    .RESET_VEC (32'h0),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .op_valid    (op_valid),
    .op          (op),
    .imm         (imm),
    .jreg        (jreg),
    .cond        (cond),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .pc          (pc),
    .taken       (taken),
    .ras_ovf     (ras_ovf),
    .ras_unf     (ras_unf)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, want finish");
    $fatal(1, "watchdog");
  end

  // reference model: RAS is a plain queue, newest at the back
  task automatic model_step(input logic ov, input logic [2:0] o, input logic [IMM_W-1:0] im,
                            input logic [PC_W-1:0] jr, input logic c, input logic st,
                            input logic rd, input logic [PC_W-1:0] rpc);
    logic t, ov_f, un_f;
    logic [PC_W-1:0] region, rel;
    t = 0; ov_f = 0; un_f = 0;
    region = ((m_pc >> (IMM_W + 2)) << (IMM_W + 2)) + (PC_W'(im) * 4);
    rel    = m_pc + PC_W'(longint'($signed(im)) * 4);
    if (!st && (rd || ov)) begin
      if (rd) begin
        m_pc = rpc - (rpc % 4);
        t = 1;
      end else begin
        case (o)
          OP_CALL: begin
            if (m_ras.size() == RAS_DEPTH) begin
              void'(m_ras.pop_front());
              ov_f = 1;
            end
            m_ras.push_back(m_pc + 4);
            m_pc = region;
            t = 1;
          end
          OP_RET: begin
            if (m_ras.size() == 0) begin
              m_pc = m_pc + 4;
              un_f = 1;
            end else begin
              m_pc = m_ras.pop_back();
              t = 1;
            end
          end
          OP_SEQ: m_pc = m_pc + 4;
          OP_JMP: begin m_pc = region; t = 1; end
          OP_JR:  begin m_pc = jr - (jr % 4); t = 1; end
          OP_BT:  begin m_pc = c ? rel : m_pc + 4; t = c; end
          OP_BF:  begin m_pc = !c ? rel : m_pc + 4; t = !c; end
          default: ;
        endcase
      end
    end
    exp_q.push_back({m_pc, t, ov_f, un_f});
  endtask

  // driver tasks
  task automatic drive(input logic ov, input logic [2:0] o, input logic [IMM_W-1:0] im,
                       input logic [PC_W-1:0] jr, input logic c, input logic st,
                       input logic rd, input logic [PC_W-1:0] rpc);
    @(negedge clk);
    op_valid = ov; op = o; imm = im; jreg = jr; cond = c;
    stall = st; redirect = rd; redirect_pc = rpc;
    model_step(ov, o, im, jr, c, st, rd, rpc);
  endtask

  task automatic do_op(input logic [2:0] o, input logic [IMM_W-1:0] im, input logic c);
    drive(1'b1, o, im, '0, c, 1'b0, 1'b0, '0);
  endtask

  task automatic do_jr(input logic [PC_W-1:0] target);
    drive(1'b1, OP_JR, '0, target, 1'b0, 1'b0, 1'b0, '0);
  endtask

  task automatic check_out(input string nm, input logic [PC_W-1:0] w_pc, input logic w_t,
                           input logic w_o, input logic w_u);
    @(posedge clk);
    #2;
    checks++;
    if (pc !== w_pc || taken !== w_t || ras_ovf !== w_o || ras_unf !== w_u) begin
      errors++;
      $display("FAIL %s: got pc=%h taken=%b ovf=%b unf=%b, want pc=%h taken=%b ovf=%b unf=%b",
               nm, pc, taken, ras_ovf, ras_unf, w_pc, w_t, w_o, w_u);
    end
  endtask

  task automatic check_reset_now(input string nm);
    checks++;
    if (pc !== 32'h0 || taken !== 1'b0 || ras_ovf !== 1'b0 || ras_unf !== 1'b0) begin
      errors++;
      $display("FAIL %s: got pc=%h taken=%b ovf=%b unf=%b, want pc=0 flags 0",
               nm, pc, taken, ras_ovf, ras_unf);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    op_valid = 0; stall = 0; redirect = 0;
    rst_n = 0;
    m_pc = 32'h0;
    m_ras.delete();
    #1;
    check_reset_now("reset_mid_run");
    @(negedge clk);
    rst_n = 1;
  endtask

  // scoreboard monitor
  always @(posedge clk) begin
    logic [EW-1:0] e;
    #1;
    if (rst_n && exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({pc, taken, ras_ovf, ras_unf} !== e) begin
        errors++;
        $display("FAIL scoreboard: got pc=%h t/o/u=%b%b%b, want pc=%h t/o/u=%b",
                 pc, taken, ras_ovf, ras_unf, e[EW-1:3], e[2:0]);
      end
    end
  end

  // stimulus
  initial begin
    rst_n = 1; op_valid = 0; op = '0; imm = '0; jreg = '0; cond = 0;
    stall = 0; redirect = 0; redirect_pc = '0;
    m_pc = 32'h0;
    #1 rst_n = 0;
    #1 check_reset_now("reset_async");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    do_op(OP_SEQ, '0, 0); check_out("seq1", 32'h4, 0, 0, 0);
    do_op(OP_SEQ, '0, 0); check_out("seq2", 32'h8, 0, 0, 0);
    do_op(OP_SEQ, '0, 0); check_out("seq3", 32'hC, 0, 0, 0);

    do_jr(32'h100); do_op(OP_BT, 16'hFFFE, 1); check_out("bt_taken", 32'hF8, 1, 0, 0);
    do_jr(32'h100); do_op(OP_BT, 16'hFFFE, 0); check_out("bt_not", 32'h104, 0, 0, 0);
    do_jr(32'h100); do_op(OP_BF, 16'hFFFE, 0); check_out("bf_taken", 32'hF8, 1, 0, 0);
    do_jr(32'h100); do_op(OP_BF, 16'hFFFE, 1); check_out("bf_not", 32'h104, 0, 0, 0);

    do_jr(32'h40);
    do_op(OP_CALL, 16'h0020, 0); check_out("call", 32'h80, 1, 0, 0);
    do_op(OP_RET, '0, 0);        check_out("ret", 32'h44, 1, 0, 0);
    do_op(OP_RET, '0, 0);        check_out("ret_empty", 32'h48, 0, 0, 1);

    do_jr(32'h1000);
    for (int i = 0; i < 4; i++) do_op(OP_CALL, 16'(16'h400 * (i + 2)), 0);
    do_op(OP_CALL, 16'h1800, 0); check_out("call_ovf", 32'h6000, 1, 1, 0);
    do_op(OP_RET, '0, 0); check_out("ret_d1", 32'h5004, 1, 0, 0);
    do_op(OP_RET, '0, 0); check_out("ret_d2", 32'h4004, 1, 0, 0);
    do_op(OP_RET, '0, 0); check_out("ret_d3", 32'h3004, 1, 0, 0);
    do_op(OP_RET, '0, 0); check_out("ret_d4", 32'h2004, 1, 0, 0);
    do_op(OP_RET, '0, 0); check_out("ret_d5_unf", 32'h2008, 0, 0, 1);

    do_op(OP_CALL, 16'h0010, 0); check_out("call_pre_redir", 32'h40, 1, 0, 0);
    drive(1'b1, OP_JR, '0, 32'h3000, 0, 0, 1, 32'h2003);
    check_out("redirect", 32'h2000, 1, 0, 0);
    drive(1'b1, OP_SEQ, '0, '0, 0, 1, 1, 32'h5000);
    check_out("stall_redirect", 32'h2000, 0, 0, 0);
    do_op(OP_RET, '0, 0); check_out("ras_kept", 32'h200C, 1, 0, 0);

    do_jr(32'hFFFF_FFFC);
    do_op(OP_SEQ, '0, 0); check_out("wrap", 32'h0, 0, 0, 0);

    do_op(OP_CALL, 16'h0010, 0);
    do_reset();
    do_op(OP_RET, '0, 0); check_out("ret_after_reset", 32'h4, 0, 0, 1);

    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 7) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
            $urandom, 1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 15) == 0), $urandom);
    end

    @(negedge clk);
    op_valid = 0; stall = 0; redirect = 0;
    model_step(0, OP_HOLD, '0, '0, 0, 0, 0, '0);
    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
